// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU / Status / result FIFO pipeline.
//   OPCODE_W        width of the opcode tag travelling with each result
//   FLAG_W          width of the Status flag vector
//   FLAG_N..FLAG_V  bit positions of the individual flags inside Status
//   OP_*            opcode encodings shared with the ALU
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int OPCODE_W = 3;
  localparam int FLAG_W   = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_SUB = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_OR  = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_XOR = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_SLT = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_SLL = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_SRL = 3'b111;

endpackage

// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
// Pointer and occupancy bookkeeping for a circular FIFO of DEPTH entries.
// Ports:
//   Clock, Resetn   rising-edge clock, asynchronous active-low reset
//   in_valid        producer offers an entry
//   out_ready       consumer wants the head entry
//   push, pop       qualified handshakes (accepted this cycle)
//   wr_ptr, rd_ptr  storage slot to write / current head slot
//   count           occupancy 0..DEPTH
//   full, empty     derived from the registered count
// ---------------------------------------------------------------------------
module fifo_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic                       in_valid,
  input  logic                       out_ready,
  output logic                       push,
  output logic                       pop,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  // Full/empty come only from registered count, so the ready signal seen by
  // the producer never depends combinationally on the consumer.
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign push  = in_valid  & ~full;
  assign pop   = out_ready & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two. Count moves
  // only when exactly one of push/pop happens.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + OCC_W'(1);
      else if (pop && !push) count <= count - OCC_W'(1);
    end
  end

endmodule

// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
// Captures finished ALU results (value, flags, opcode) into a small
// show-ahead circular FIFO and drains them over a valid/ready handshake.
// Also keeps a sticky OR of all accepted flags and a saturating count of
// accepted results for debug.
// Ports:
//   Clock, Resetn                 clock, asynchronous active-low reset
//   InValid/InReady               producer handshake
//   FinalOut, Status, OPCode      entry being offered
//   OutValid/OutReady             consumer handshake
//   OutData, OutStatus, OutOPCode head entry (zero while empty)
//   Count, Full, Empty            occupancy
//   StickyFlags, ClearSticky      accumulated flags and their clear
//   ResultCnt                     accepted pushes since reset (saturating)
// ---------------------------------------------------------------------------
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int FLAG_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [DATA_W-1:0]         FinalOut,
  input  logic [FLAG_W-1:0]         Status,
  input  logic [OPCODE_W-1:0]       OPCode,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [DATA_W-1:0]         OutData,
  output logic [FLAG_W-1:0]         OutStatus,
  output logic [OPCODE_W-1:0]       OutOPCode,
  output logic [$clog2(DEPTH):0]    Count,
  output logic                      Full,
  output logic                      Empty,
  output logic [FLAG_W-1:0]         StickyFlags,
  input  logic                      ClearSticky,
  output logic [CNT_W-1:0]          ResultCnt
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [FLAG_W-1:0]   flags;
    logic [OPCODE_W-1:0] op;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic               push;
  logic               pop;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .in_valid  (InValid),
    .out_ready (OutReady),
    .push      (push),
    .pop       (pop),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (Count),
    .full      (Full),
    .empty     (Empty)
  );

  assign InReady  = ~Full;
  assign OutValid = ~Empty;

  // Storage is not reset; stale contents are hidden by gating the head
  // outputs while empty, which also makes them drop to zero the instant
  // reset clears the count.
  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= '{data: FinalOut, flags: Status, op: OPCode};
  end

  assign head      = Empty ? '0 : mem[rd_ptr];
  assign OutData   = head.data;
  assign OutStatus = head.flags;
  assign OutOPCode = head.op;

  // A push coinciding with a clear restarts the history from that entry's
  // flags instead of losing them.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      StickyFlags <= '0;
    end else if (ClearSticky && push) begin
      StickyFlags <= Status;
    end else if (ClearSticky) begin
      StickyFlags <= '0;
    end else if (push) begin
      StickyFlags <= StickyFlags | Status;
    end
  end

  // Accepted-result counter holds at all-ones rather than wrapping.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ResultCnt <= '0;
    end else if (push && (ResultCnt != '1)) begin
      ResultCnt <= ResultCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_alu_result_fifo
// Directed bench for alu_result_fifo (DEPTH=4) with hand-computed
// expectations for fill, drain, streaming, sticky flags and async reset.
// ---------------------------------------------------------------------------
module tb_alu_result_fifo;

  logic        Clock;
  logic        Resetn;
  logic        InValid;
  logic        InReady;
  logic [31:0] FinalOut;
  logic [3:0]  Status;
  logic [2:0]  OPCode;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutData;
  logic [3:0]  OutStatus;
  logic [2:0]  OutOPCode;
  logic [2:0]  Count;
  logic        Full;
  logic        Empty;
  logic [3:0]  StickyFlags;
  logic        ClearSticky;
  logic [15:0] ResultCnt;

  int checks = 0;
  int errors = 0;

  alu_result_fifo #(
    .DEPTH  (4),
    .DATA_W (32),
    .FLAG_W (4),
    .CNT_W  (16)
  ) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .InValid     (InValid),
    .InReady     (InReady),
    .FinalOut    (FinalOut),
    .Status      (Status),
    .OPCode      (OPCode),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .OutData     (OutData),
    .OutStatus   (OutStatus),
    .OutOPCode   (OutOPCode),
    .Count       (Count),
    .Full        (Full),
    .Empty       (Empty),
    .StickyFlags (StickyFlags),
    .ClearSticky (ClearSticky),
    .ResultCnt   (ResultCnt)
  );

  // Free-running 10-unit clock.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Guard against any hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, settle 1 unit after it.
  task automatic applyStimulus(input logic iv, input logic [31:0] d,
                               input logic [3:0] st, input logic [2:0] op,
                               input logic ordy, input logic clr);
    InValid     = iv;
    FinalOut    = d;
    Status      = st;
    OPCode      = op;
    OutReady    = ordy;
    ClearSticky = clr;
    @(posedge Clock);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " Empty"},     32'(Empty),       32'd1);
    checkOutput({tag, " Full"},      32'(Full),        32'd0);
    checkOutput({tag, " InReady"},   32'(InReady),     32'd1);
    checkOutput({tag, " OutValid"},  32'(OutValid),    32'd0);
    checkOutput({tag, " Count"},     32'(Count),       32'd0);
    checkOutput({tag, " Sticky"},    32'(StickyFlags), 32'd0);
    checkOutput({tag, " ResultCnt"}, 32'(ResultCnt),   32'd0);
    checkOutput({tag, " OutData"},   OutData,          32'd0);
    checkOutput({tag, " OutStatus"}, 32'(OutStatus),   32'd0);
    checkOutput({tag, " OutOPCode"}, 32'(OutOPCode),   32'd0);
  endtask

  logic [31:0] expData [4];
  logic [3:0]  expStat [4];
  logic [2:0]  expOp   [4];

  initial begin
    Resetn = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkResetState("reset");
    Resetn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkResetState("idle");

    // Two pushes, consumer stalled.
    applyStimulus(1, 32'd25, 4'b0000, 3'd0, 0, 0);
    checkOutput("push1 OutValid", 32'(OutValid), 32'd1);
    checkOutput("push1 OutData",  OutData,       32'd25);
    checkOutput("push1 Count",    32'(Count),    32'd1);
    applyStimulus(1, 32'hFFFF_FFFB, 4'b1000, 3'd1, 0, 0);
    checkOutput("push2 Count",    32'(Count),       32'd2);
    checkOutput("push2 OutData",  OutData,          32'd25);
    checkOutput("push2 Sticky",   32'(StickyFlags), 32'b1000);
    checkOutput("push2 ResultCnt",32'(ResultCnt),   32'd2);

    // Fill to full.
    applyStimulus(1, 32'd100, 4'b0001, 3'd2, 0, 0);
    applyStimulus(1, 32'd101, 4'b0100, 3'd3, 0, 0);
    checkOutput("fill Full",      32'(Full),        32'd1);
    checkOutput("fill InReady",   32'(InReady),     32'd0);
    checkOutput("fill Count",     32'(Count),       32'd4);
    checkOutput("fill Sticky",    32'(StickyFlags), 32'b1101);

    // Fifth offer while full must be ignored.
    applyStimulus(1, 32'd999, 4'b0010, 3'd7, 0, 0);
    checkOutput("overfill Count",     32'(Count),       32'd4);
    checkOutput("overfill ResultCnt", 32'(ResultCnt),   32'd4);
    checkOutput("overfill Sticky",    32'(StickyFlags), 32'b1101);
    checkOutput("overfill OutData",   OutData,          32'd25);

    // Drain in order.
    expData = '{32'd25, 32'hFFFF_FFFB, 32'd100, 32'd101};
    expStat = '{4'b0000, 4'b1000, 4'b0001, 4'b0100};
    expOp   = '{3'd0, 3'd1, 3'd2, 3'd3};
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain%0d OutData", i),   OutData,          expData[i]);
      checkOutput($sformatf("drain%0d OutStatus", i), 32'(OutStatus),   32'(expStat[i]));
      checkOutput($sformatf("drain%0d OutOPCode", i), 32'(OutOPCode),   32'(expOp[i]));
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput($sformatf("drain%0d Count", i),     32'(Count),       32'(3 - i));
      checkOutput($sformatf("drain%0d InReady", i),   32'(InReady),     32'd1);
    end
    checkOutput("drained Empty",   32'(Empty),    32'd1);
    checkOutput("drained OutData", OutData,       32'd0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("underflow Count", 32'(Count),    32'd0);
    checkOutput("underflow Empty", 32'(Empty),    32'd1);

    // Continuous streaming, pointers wrap; last push also clears sticky.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 32'(200 + i), (i == 9) ? 4'b0010 : 4'b0000, 3'(i), 1, (i == 9));
      checkOutput($sformatf("stream%0d Count", i),   32'(Count), 32'd1);
      checkOutput($sformatf("stream%0d OutData", i), OutData,    32'(200 + i));
    end
    checkOutput("stream Sticky",    32'(StickyFlags), 32'b0010);
    checkOutput("stream ResultCnt", 32'(ResultCnt),   32'd14);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("stream drain Empty", 32'(Empty), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("clear Sticky", 32'(StickyFlags), 32'd0);

    // Three pushes, then asynchronous reset between clock edges.
    applyStimulus(1, 32'd300, 4'b1111, 3'd5, 0, 0);
    applyStimulus(1, 32'd301, 4'b0001, 3'd6, 0, 0);
    applyStimulus(1, 32'd302, 4'b0010, 3'd7, 0, 0);
    InValid = 1'b0;
    checkOutput("prereset Count", 32'(Count), 32'd3);
    #3;
    Resetn = 1'b0;
    #1;
    checkResetState("async");
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    applyStimulus(1, 32'd400, 4'b0100, 3'd4, 0, 0);
    checkOutput("postreset OutData",   OutData,        32'd400);
    checkOutput("postreset OutOPCode", 32'(OutOPCode), 32'd4);
    checkOutput("postreset Count",     32'(Count),     32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
